// File: rtl/spi_px_master.sv
// -----------------------------------------------------------------------------
// spi_px_master
//   SPI host-side pixel streamer (mode 0: CPOL=0, CPHA=0, MSB first).
//   One PIXEL_BITS word is sent per chip-select frame. In the same
//   full-duplex frame, the word that the slave shifts back is collected.
//
//   Frame timeline (D = CLK_DIV, P = PIXEL_BITS), counted from the
//   accepting edge:
//     SETUP : D cycles, CS low, SCK low (sdo already carries the MSB)
//     SHIFT : 2*P half-periods of D cycles. SCK starts low and toggles at
//             the end of each half-period.
//     HOLD  : D cycles, CS low, SCK low
//     GAP   : D cycles, CS high (minimum deselect time)
//     DONE  : 1 cycle, publishes rx_data_o / rx_valid_o
//
// Ports:
//   clk_i       system clock
//   reset_i     synchronous reset, active-high
//   tx_data_i   pixel word to send
//   tx_valid_i  tx_data_i is valid
//   tx_ready_o  word accepted this cycle when valid (decoded from state)
//   rx_data_o   word received during the last completed frame
//   rx_valid_o  one-cycle pulse; rx_data_o is valid
//   busy_o      transfer in progress
//   spi_sck_o   SPI clock
//   spi_cs_o    chip select, active-low
//   spi_sdo_o   MOSI
//   spi_sdi_i   MISO
// -----------------------------------------------------------------------------
module spi_px_master #(
    parameter int PIXEL_BITS = 24,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [PIXEL_BITS-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [PIXEL_BITS-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  spi_sck_o,
    output logic                  spi_cs_o,
    output logic                  spi_sdo_o,
    input  logic                  spi_sdi_i
);

    localparam int                HALF_W    = $clog2(2 * PIXEL_BITS + 1);
    localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * PIXEL_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                  state_r;
    logic [7:0]              div_cnt_r;
    logic [HALF_W-1:0]       half_cnt_r;
    logic [PIXEL_BITS-1:0]   tx_sr_r;
    logic [PIXEL_BITS-1:0]   rx_sr_r;
    logic [PIXEL_BITS-1:0]   rx_data_r;
    logic                    rx_valid_r;
    logic                    busy_r;
    logic                    sck_r;
    logic                    cs_r;
    logic                    sdo_r;
    logic                    div_last_s;

    // The divider reaching its last count ends every timed phase.
    assign div_last_s = (div_cnt_r == DIV_LAST);

    // tx_ready_o is the only output decoded from state and not registered.
    assign tx_ready_o = (state_r == ST_IDLE);
    assign rx_data_o  = rx_data_r;
    assign rx_valid_o = rx_valid_r;
    assign busy_o     = busy_r;
    assign spi_sck_o  = sck_r;
    assign spi_cs_o   = cs_r;
    assign spi_sdo_o  = sdo_r;

    // Frame sequencer: state, divider, shift registers and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= 8'd0;
            half_cnt_r <= '0;
            tx_sr_r    <= '0;
            rx_sr_r    <= '0;
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            sck_r      <= 1'b0;
            cs_r       <= 1'b1;
            sdo_r      <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    div_cnt_r  <= 8'd0;
                    half_cnt_r <= '0;
                    if (tx_valid_i) begin
                        tx_sr_r <= tx_data_i;
                        rx_sr_r <= '0;
                        cs_r    <= 1'b0;
                        sdo_r   <= tx_data_i[PIXEL_BITS-1];
                        busy_r  <= 1'b1;
                        state_r <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (div_last_s) begin
                        div_cnt_r <= 8'd0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (div_last_s) begin
                        div_cnt_r  <= 8'd0;
                        sck_r      <= ~sck_r;
                        half_cnt_r <= half_cnt_r + HALF_W'(1);
                        // Falling SCK: sample MISO late (after a full high phase),
                        // then present the next MOSI bit unless this was the last one.
                        if (sck_r) begin
                            rx_sr_r <= {rx_sr_r[PIXEL_BITS-2:0], spi_sdi_i};
                            if (half_cnt_r == HALF_LAST) begin
                                half_cnt_r <= '0;
                                state_r    <= ST_HOLD;
                            end else begin
                                tx_sr_r <= {tx_sr_r[PIXEL_BITS-2:0], 1'b0};
                                sdo_r   <= tx_sr_r[PIXEL_BITS-2];
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (div_last_s) begin
                        div_cnt_r <= 8'd0;
                        cs_r      <= 1'b1;
                        sdo_r     <= 1'b0;
                        state_r   <= ST_GAP;
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (div_last_s) begin
                        div_cnt_r <= 8'd0;
                        state_r   <= ST_DONE;
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    rx_data_r  <= rx_sr_r;
                    rx_valid_r <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    // Unreachable encodings recover to a safe, deselected idle.
                    state_r    <= ST_IDLE;
                    div_cnt_r  <= 8'd0;
                    half_cnt_r <= '0;
                    busy_r     <= 1'b0;
                    sck_r      <= 1'b0;
                    cs_r       <= 1'b1;
                    sdo_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_px_master.sv
module tb_spi_px_master;

    localparam int PB   = 24;
    localparam int DIV  = 2;
    localparam int DIV1 = 4;
    localparam int LAT  = (3 + 2 * PB) * DIV + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i;
    // DUT0: CLK_DIV=2, main traffic
    logic [PB-1:0] tx_data0;
    logic          tx_valid0, tx_ready0, rx_valid0, busy0, sck0, cs0, sdo0, sdi0;
    logic [PB-1:0] rx_data0;
    // DUT1: CLK_DIV=4, idle check, MISO looped back
    logic [PB-1:0] tx_data1;
    logic          tx_valid1, tx_ready1, rx_valid1, busy1, sck1, cs1, sdo1;
    logic [PB-1:0] rx_data1;

    int n_vec = 0;
    int n_err = 0;

    // Slave model and monitors
    bit            loop_mode = 1'b1;
    logic [PB-1:0] resp = '0;
    logic [PB-1:0] mosi_cap = '0;
    int            slv_idx = -1;
    int            rises = 0, sck_edges = 0;
    int            lowrun = 0, highrun = 0, last_low = 0, last_high = 0;
    int            viol = 0, rxv_cnt = 0;
    logic          slv_out;

    assign slv_out = (slv_idx >= 0 && slv_idx < PB) ? resp[slv_idx] : 1'b0;
    assign sdi0    = loop_mode ? sdo0 : slv_out;

    spi_px_master #(.PIXEL_BITS(PB), .CLK_DIV(DIV)) dut0 (
        .clk_i(clk), .reset_i(reset_i),
        .tx_data_i(tx_data0), .tx_valid_i(tx_valid0), .tx_ready_o(tx_ready0),
        .rx_data_o(rx_data0), .rx_valid_o(rx_valid0), .busy_o(busy0),
        .spi_sck_o(sck0), .spi_cs_o(cs0), .spi_sdo_o(sdo0), .spi_sdi_i(sdi0)
    );

    spi_px_master #(.PIXEL_BITS(PB), .CLK_DIV(DIV1)) dut1 (
        .clk_i(clk), .reset_i(reset_i),
        .tx_data_i(tx_data1), .tx_valid_i(tx_valid1), .tx_ready_o(tx_ready1),
        .rx_data_o(rx_data1), .rx_valid_o(rx_valid1), .busy_o(busy1),
        .spi_sck_o(sck1), .spi_cs_o(cs1), .spi_sdo_o(sdo1), .spi_sdi_i(sdo1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave: loads its MSB when selected
    always @(negedge cs0) slv_idx <= PB - 1;

    // Slave: samples MOSI on rising SCK, advances its output on falling SCK
    always @(posedge sck0 or negedge sck0) begin
        sck_edges <= sck_edges + 1;
        if (sck0) begin
            mosi_cap <= {mosi_cap[PB-2:0], sdo0};
            rises    <= rises + 1;
        end else if (!cs0) begin
            slv_idx <= slv_idx - 1;
        end
    end

    // Run lengths of CS low/high, protocol violations and rx_valid pulses
    always @(negedge clk) begin
        if (sck0 && cs0) viol <= viol + 1;
        if (rx_valid0) rxv_cnt <= rxv_cnt + 1;
        if (!cs0) begin
            lowrun  <= lowrun + 1;
            highrun <= 0;
            if (highrun != 0) last_high <= highrun;
        end else begin
            highrun <= highrun + 1;
            lowrun  <= 0;
            if (lowrun != 0) last_low <= lowrun;
        end
    end

    // One frame on DUT0; expected values come from the frame rules alone
    task automatic run_frame(input logic [PB-1:0] word, input bit lb,
                             input logic [PB-1:0] rsp, input bit poke);
        int r0, lat;
        logic [PB-1:0] exp_rx;
        loop_mode = lb;
        resp      = rsp;
        exp_rx    = lb ? word : rsp;
        r0        = rises;
        @(negedge clk);
        check_eq("ready_idle", tx_ready0, 1);
        tx_data0  = word;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        tx_data0  = PB'($urandom);
        lat = 0;
        while (!rx_valid0 && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 3 * DIV + 5) begin
                check_eq("ready_busy", tx_ready0, 0);
                check_eq("busy_shift", busy0, 1);
                tx_valid0 = 1'b1;
                tx_data0  = 24'hDEAD00;
            end else begin
                tx_valid0 = 1'b0;
            end
        end
        check_eq("latency", lat, LAT);
        check_eq("rx_data", rx_data0, exp_rx);
        check_eq("mosi_bits", mosi_cap, word);
        check_eq("sck_rises", rises - r0, PB);
        check_eq("cs_low_len", last_low, (2 * PB + 2) * DIV);
        @(negedge clk);
        check_eq("rxv_pulse", rx_valid0, 0);
        check_eq("rx_hold", rx_data0, exp_rx);
        check_eq("busy_idle", busy0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, e0, r0, bad;
        reset_i   = 1'b1;
        tx_data0  = '0;
        tx_valid0 = 1'b0;
        tx_data1  = 24'h5A5A5A;
        tx_valid1 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", tx_ready0, 1);
        check_eq("rst_rxdata", rx_data0, 0);
        check_eq("rst_rxvalid", rx_valid0, 0);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_sck", sck0, 0);
        check_eq("rst_cs", cs0, 1);
        check_eq("rst_sdo", sdo0, 0);
        reset_i = 1'b0;

        // Directed frames
        run_frame(24'hA5C33C, 1'b1, 24'h000000, 1'b0);
        run_frame(24'hFFFFFF, 1'b0, 24'h123456, 1'b0);
        run_frame(24'h3C3C3C, 1'b1, 24'h000000, 1'b1);

        // Randomized frames
        for (int i = 0; i < 8; i++)
            run_frame(PB'($urandom), i[0], PB'($urandom), (i % 3) == 1);

        // Back-to-back with tx_valid held high
        loop_mode = 1'b1;
        @(negedge clk);
        tx_data0  = 24'h000001;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_data0 = 24'h800000;
        n = 0;
        while (!rx_valid0 && n < 2000) begin @(negedge clk); n++; end
        check_eq("b2b_lat1", n, LAT);
        check_eq("b2b_rx1", rx_data0, 24'h000001);
        check_eq("b2b_ready", tx_ready0, 1);
        @(negedge clk);
        tx_valid0 = 1'b0;
        check_eq("b2b_busy2", busy0, 1);
        check_eq("b2b_cs2", cs0, 0);
        n = 0;
        while (!rx_valid0 && n < 2000) begin @(negedge clk); n++; end
        check_eq("b2b_lat2", n, LAT);
        check_eq("b2b_rx2", rx_data0, 24'h800000);
        check_eq("b2b_gap", last_high, DIV + 2);

        // Reset at the 10th SCK edge
        e0 = sck_edges;
        @(negedge clk);
        tx_data0  = 24'h5A5A5A;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        n = 0;
        while ((sck_edges - e0) < 10 && n < 500) begin @(negedge clk); n++; end
        check_eq("sck_edges10", sck_edges - e0, 10);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check_eq("mid_rst_cs", cs0, 1);
        check_eq("mid_rst_sck", sck0, 0);
        check_eq("mid_rst_sdo", sdo0, 0);
        check_eq("mid_rst_busy", busy0, 0);
        check_eq("mid_rst_ready", tx_ready0, 1);
        check_eq("mid_rst_rxdata", rx_data0, 0);
        r0 = rxv_cnt;
        repeat (LAT + 20) @(negedge clk);
        check_eq("no_rxv_after_rst", rxv_cnt - r0, 0);
        run_frame(24'h0F0F0F, 1'b1, 24'h000000, 1'b0);

        // DUT1 (CLK_DIV=4) idle: no activity for 50 cycles
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (cs1 !== 1'b1 || sck1 !== 1'b0 || sdo1 !== 1'b0 || busy1 !== 1'b0 ||
                rx_valid1 !== 1'b0 || tx_ready1 !== 1'b1 || rx_data1 !== '0)
                bad++;
        end
        check_eq("idle_activity", bad, 0);
        check_eq("idle_cs", cs1, 1);
        check_eq("sck_while_cs_high", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
